// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: memory request/ack, decoder handshake, redirect.
// master = fetch unit side, slave = memory/decoder/branch side.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic              run;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_data;
   logic [31:0]       op_code;
   logic              op_valid;
   logic              op_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] fetch_pc;

   modport master (
      input  run, imem_ack, imem_data,
      input  op_ready, redirect, redirect_pc,
      output imem_req, imem_addr,
      output op_code, op_valid, fetch_pc
   );

   modport slave (
      output run, imem_ack, imem_data,
      output op_ready, redirect, redirect_pc,
      input  imem_req, imem_addr,
      input  op_code, op_valid, fetch_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory request,
// prefetch FIFO towards the decoder, and branch redirect flush.
module instr_fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic clk,
   input  logic rst_n,
   instr_fetch_unit_if.master bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   logic [31:0]       mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              ack;
   logic              issue;
   logic              push;
   logic              pop;
   logic              valid;

   assign valid = (cnt_q != '0);
   assign ack   = req_q && bus.imem_ack;
   assign pop   = valid && bus.op_ready && !bus.redirect;
   assign issue = (state_q == S_IDLE) && bus.run &&
                  !bus.redirect && (cnt_q < CW'(DEPTH));

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.fetch_pc  = pc_q;
   assign bus.op_valid  = valid;
   assign bus.op_code   = valid ? mem_q[rptr_q] : '0;

   // Fetch FSM next state, request control and PC update.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      pc_d    = pc_q;
      push    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (issue) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ack) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
               if (!bus.redirect) begin
                  push = 1'b1;
                  pc_d = pc_q + ADDR_W'(1);
               end
            end else if (bus.redirect) begin
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (ack) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
      if (bus.redirect) begin
         pc_d = bus.redirect_pc;
      end
   end

   // Prefetch FIFO pointer and occupancy next state; redirect flushes.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (bus.redirect) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // FSM, request and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // FIFO storage, written with the acked word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wptr_q] <= bus.imem_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder,
// scoreboard of expected op_code words and expected request addresses.
module tb_instr_fetch_unit;

   logic clk;
   logic rst_n;

   instr_fetch_unit_if #(.ADDR_W(8)) bus ();

   instr_fetch_unit #(
      .ADDR_W(8),
      .DEPTH(2),
      .RESET_PC(8'h00)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_pop = 0;
   int gap = 0;

   logic [31:0] sb [$];
   logic [7:0]  exp_addr [$];

   logic mem_en = 1'b0;
   logic force_ack = 1'b0;
   int   ack_delay = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory model: mem[a] = 0x1000_0000 + a, ack after ack_delay cycles.
   initial begin
      int wcnt;
      wcnt = 0;
      bus.imem_ack = 1'b0;
      bus.imem_data = '0;
      forever begin
         @(negedge clk);
         if (mem_en && bus.imem_req) begin
            if (wcnt >= ack_delay) begin
               bus.imem_ack = 1'b1;
               bus.imem_data = 32'h1000_0000 + {24'd0, bus.imem_addr};
               wcnt = 0;
            end else begin
               bus.imem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            bus.imem_ack = force_ack;
            wcnt = 0;
         end
      end
   end

   // Scoreboard monitor: pops and completed request addresses.
   initial begin
      logic [31:0] ew;
      logic [7:0]  ea;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.op_valid && bus.op_ready && !bus.redirect) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: op_code=%h, none expected",
                        bus.op_code);
            end else begin
               ew = sb.pop_front();
               if (bus.op_code !== ew) begin
                  errors++;
                  $display("FAIL pop_word: op_code=%h, expected %h",
                           bus.op_code, ew);
               end
            end
            gap = cyc - last_pop;
            last_pop = cyc;
         end
         if (rst_n && bus.imem_req && bus.imem_ack &&
             exp_addr.size() > 0) begin
            checks++;
            ea = exp_addr.pop_front();
            if (bus.imem_addr !== ea) begin
               errors++;
               $display("FAIL req_addr: imem_addr=%h, expected %h",
                        bus.imem_addr, ea);
            end
         end
      end
   end

   task automatic wait_req(input logic val, input int maxc);
      int i;
      i = 0;
      while (bus.imem_req !== val && i < maxc) begin
         @(posedge clk);
         #1;
         i++;
      end
      checks++;
      if (bus.imem_req !== val) begin
         errors++;
         $display("FAIL wait_req: imem_req=%b, expected %b in %0d cycles",
                  bus.imem_req, val, maxc);
      end
   endtask

   task automatic wait_sb(input int maxc);
      int i;
      i = 0;
      while (sb.size() != 0 && i < maxc) begin
         @(posedge clk);
         #1;
         i++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL wait_sb: %0d words pending, expected 0",
                  sb.size());
      end
   endtask

   task automatic settle(input logic [7:0] pc);
      bus.run = 1'b0;
      bus.op_ready = 1'b0;
      wait_req(1'b0, 20);
      @(posedge clk);
      #1;
      bus.redirect = 1'b1;
      bus.redirect_pc = pc;
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.run = 1'b0;
      bus.op_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      #3;
      checks += 5;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_req: got %b, expected 0", bus.imem_req);
      end
      if (bus.imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL rst_addr: got %h, expected 00", bus.imem_addr);
      end
      if (bus.fetch_pc !== 8'h00) begin
         errors++;
         $display("FAIL rst_pc: got %h, expected 00", bus.fetch_pc);
      end
      if (bus.op_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid: got %b, expected 0", bus.op_valid);
      end
      if (bus.op_code !== 32'h0) begin
         errors++;
         $display("FAIL rst_code: got %h, expected 0", bus.op_code);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 3; i++) begin
         sb.push_back(32'h1000_0000 + i);
      end
      for (int i = 0; i < 4; i++) begin
         exp_addr.push_back(8'(i));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_en = 1'b1;
      ack_delay = 0;
      bus.run = 1'b1;
      bus.op_ready = 1'b1;
      wait_sb(30);
      bus.run = 1'b0;
      bus.op_ready = 1'b0;
      checks++;
      if (gap != 2) begin
         errors++;
         $display("FAIL stream_gap: %0d cycles per word, expected 2", gap);
      end
      settle(8'h00);
   endtask

   task automatic test_backpressure();
      exp_addr.push_back(8'h00);
      exp_addr.push_back(8'h01);
      bus.run = 1'b1;
      bus.op_ready = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      checks += 4;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL bp_req: got %b, expected 0", bus.imem_req);
      end
      if (bus.op_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid: got %b, expected 1", bus.op_valid);
      end
      if (bus.op_code !== 32'h1000_0000) begin
         errors++;
         $display("FAIL bp_hold: got %h, expected 10000000", bus.op_code);
      end
      if (bus.fetch_pc !== 8'h02) begin
         errors++;
         $display("FAIL bp_pc: got %h, expected 02", bus.fetch_pc);
      end
      sb.push_back(32'h1000_0000);
      bus.op_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.op_ready = 1'b0;
      exp_addr.push_back(8'h02);
      checks++;
      if (bus.op_code !== 32'h1000_0001) begin
         errors++;
         $display("FAIL bp_next: got %h, expected 10000001", bus.op_code);
      end
      @(posedge clk);
      #1;
      checks += 2;
      if (bus.imem_req !== 1'b1) begin
         errors++;
         $display("FAIL bp_reissue: got %b, expected 1", bus.imem_req);
      end
      if (bus.imem_addr !== 8'h02) begin
         errors++;
         $display("FAIL bp_addr: got %h, expected 02", bus.imem_addr);
      end
      settle(8'h03);
   endtask

   task automatic test_redirect_discard();
      exp_addr.push_back(8'h03);
      exp_addr.push_back(8'h04);
      ack_delay = 0;
      bus.run = 1'b1;
      bus.op_ready = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      ack_delay = 3;
      sb.push_back(32'h1000_0003);
      bus.op_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.op_ready = 1'b0;
      wait_req(1'b1, 10);
      exp_addr.push_back(8'h05);
      exp_addr.push_back(8'h40);
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'h40;
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
      checks += 4;
      if (bus.op_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_flush: op_valid=%b, expected 0", bus.op_valid);
      end
      if (bus.fetch_pc !== 8'h40) begin
         errors++;
         $display("FAIL rd_pc: got %h, expected 40", bus.fetch_pc);
      end
      if (bus.imem_req !== 1'b1) begin
         errors++;
         $display("FAIL rd_discard_req: got %b, expected 1", bus.imem_req);
      end
      if (bus.imem_addr !== 8'h05) begin
         errors++;
         $display("FAIL rd_discard_addr: got %h, expected 05",
                  bus.imem_addr);
      end
      sb.push_back(32'h1000_0040);
      bus.op_ready = 1'b1;
      wait_sb(40);
      settle(8'h08);
   endtask

   task automatic test_redirect_ack();
      exp_addr.push_back(8'h08);
      exp_addr.push_back(8'h20);
      ack_delay = 0;
      bus.run = 1'b1;
      bus.op_ready = 1'b0;
      wait_req(1'b1, 10);
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'h20;
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
      checks += 3;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL ra_req: got %b, expected 0", bus.imem_req);
      end
      if (bus.op_valid !== 1'b0) begin
         errors++;
         $display("FAIL ra_drop: op_valid=%b, expected 0", bus.op_valid);
      end
      if (bus.fetch_pc !== 8'h20) begin
         errors++;
         $display("FAIL ra_pc: got %h, expected 20", bus.fetch_pc);
      end
      @(posedge clk);
      #1;
      checks += 2;
      if (bus.imem_req !== 1'b1) begin
         errors++;
         $display("FAIL ra_issue: got %b, expected 1", bus.imem_req);
      end
      if (bus.imem_addr !== 8'h20) begin
         errors++;
         $display("FAIL ra_addr: got %h, expected 20", bus.imem_addr);
      end
      sb.push_back(32'h1000_0020);
      bus.op_ready = 1'b1;
      wait_sb(20);
      settle(8'hFF);
   endtask

   task automatic test_wrap();
      checks++;
      if (bus.fetch_pc !== 8'hFF) begin
         errors++;
         $display("FAIL wrap_start: got %h, expected ff", bus.fetch_pc);
      end
      exp_addr.push_back(8'hFF);
      exp_addr.push_back(8'h00);
      sb.push_back(32'h1000_00FF);
      sb.push_back(32'h1000_0000);
      ack_delay = 0;
      bus.run = 1'b1;
      bus.op_ready = 1'b1;
      wait_sb(20);
      settle(8'h10);
   endtask

   task automatic test_reset_mid();
      ack_delay = 3;
      bus.run = 1'b1;
      bus.op_ready = 1'b0;
      wait_req(1'b1, 10);
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rm_req: got %b, expected 0", bus.imem_req);
      end
      if (bus.imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL rm_addr: got %h, expected 00", bus.imem_addr);
      end
      if (bus.fetch_pc !== 8'h00) begin
         errors++;
         $display("FAIL rm_pc: got %h, expected 00", bus.fetch_pc);
      end
      if (bus.op_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_valid: got %b, expected 0", bus.op_valid);
      end
      mem_en = 1'b0;
      force_ack = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      force_ack = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rm_late_ack: imem_req=%b, expected 0",
                  bus.imem_req);
      end
      mem_en = 1'b1;
      ack_delay = 0;
      exp_addr.push_back(8'h00);
      sb.push_back(32'h1000_0000);
      bus.op_ready = 1'b1;
      rst_n = 1'b1;
      wait_sb(20);
      settle(8'h00);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_discard();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      checks++;
      if (exp_addr.size() != 0) begin
         errors++;
         $display("FAIL addr_left: %0d addresses unseen, expected 0",
                  exp_addr.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
